// File: rtl/bus_pkg.sv
// Shared bus dimensions for the serial slave port and its memory side.
package bus_pkg;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 8;
endpackage

// File: rtl/slave_port.sv
// Serial bus slave: shifts in address/write data LSB-first, issues one memory access,
// and returns read data serially, optionally releasing the bus through a split read.
module slave_port
    import bus_pkg::*;
#(
    parameter logic SPLIT_EN = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  bus_valid_i,
    input  logic                  bus_mode_i,
    input  logic                  bus_sdata_i,
    output logic                  bus_ready_o,
    output logic                  bus_rvalid_o,
    output logic                  bus_rdata_o,
    output logic                  bus_ack_o,
    output logic                  bus_err_o,
    output logic                  bus_split_o,
    output logic                  split_req_o,
    input  logic                  split_grant_i,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  mem_split_start_o,
    input  logic                  mem_split_ready_i
);

    localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CntW = $clog2(MaxW + 1);
    // Bit 0 of the address is taken in IDLE, so ADDR only counts the remaining bits.
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 2);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StWdata, StReq, StWait, StSplit, StResume, StResp
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_valid_i) begin
                    we_d    = bus_mode_i;
                    addr_d  = {bus_sdata_i, addr_q[ADDR_WIDTH-1:1]};
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!bus_valid_i) begin
                    state_d = StIdle;
                end else begin
                    addr_d = {bus_sdata_i, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == AddrLast) state_d = we_q ? StWdata : StReq;
                end
            end
            StWdata: begin
                if (!bus_valid_i) begin
                    state_d = StIdle;
                end else begin
                    wdata_d = {bus_sdata_i, wdata_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DataLast) state_d = StReq;
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                if (mem_ready_i) begin
                    if (mem_err_i || we_q) begin
                        ack_d   = 1'b1;
                        err_d   = mem_err_i;
                        state_d = StIdle;
                    end else begin
                        rdata_d = mem_rdata_i;
                        state_d = StResp;
                    end
                end else if (SPLIT_EN && !we_q) begin
                    state_d = StSplit;
                end
            end
            StSplit: begin
                if (mem_split_ready_i) begin
                    rdata_d = mem_rdata_i;
                    state_d = StResume;
                end
            end
            StResume: if (split_grant_i) state_d = StResp;
            StResp: begin
                rdata_d = {1'b0, rdata_q[DATA_WIDTH-1:1]};
                if (cnt_q == DataLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        cnt_d = (state_d != state_q || state_q == StIdle) ? '0 : cnt_q + CntW'(1);
    end

    always_comb begin
        bus_ready_o       = (state_q == StIdle);
        mem_valid_o       = (state_q == StReq);
        mem_split_start_o = (state_q == StReq) && SPLIT_EN && !we_q;
        bus_split_o       = (state_q == StSplit) || (state_q == StResume);
        split_req_o       = (state_q == StResume);
        bus_rvalid_o      = (state_q == StResp);
        bus_rdata_o       = (state_q == StResp) && rdata_q[0];
        // Writes and errors ack one cycle after mem_ready; reads ack on the last data bit.
        bus_ack_o         = ack_q || ((state_q == StResp) && (cnt_q == DataLast));
        bus_err_o         = err_q;
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: one instance per SPLIT_EN setting, exercised in turn.
module tb_slave_port;
    import bus_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic          split;
    } req_t;

    typedef struct {
        logic          is_read;
        logic          err;
        logic [DW-1:0] data;
        int            sreq;
        int            bsplit;
        logic          lat_chk;
    } resp_t;

    typedef struct {
        int   lat;
        logic err;
        logic split;
        int   slat;
        int   g;
    } plan_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          bus_valid, bus_mode, bus_sdata, split_grant;
    logic          mem_ready, mem_err, mem_split_ready;
    logic [DW-1:0] mem_rdata;
    bit            sel;
    logic          valid0, valid1;
    assign valid0 = bus_valid && (sel == 1'b0);
    assign valid1 = bus_valid && (sel == 1'b1);

    logic          ready[2], rvalid[2], rdata[2], ack[2], err[2], bsplit[2], sreq[2];
    logic          mvalid[2], mwe[2], msplit[2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mwdata[2];

    slave_port #(.SPLIT_EN(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus_valid_i(valid0), .bus_mode_i(bus_mode),
        .bus_sdata_i(bus_sdata), .bus_ready_o(ready[0]), .bus_rvalid_o(rvalid[0]),
        .bus_rdata_o(rdata[0]), .bus_ack_o(ack[0]), .bus_err_o(err[0]),
        .bus_split_o(bsplit[0]), .split_req_o(sreq[0]), .split_grant_i(split_grant),
        .mem_valid_o(mvalid[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
        .mem_we_o(mwe[0]), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .mem_err_i(mem_err), .mem_split_start_o(msplit[0]),
        .mem_split_ready_i(mem_split_ready)
    );

    slave_port #(.SPLIT_EN(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus_valid_i(valid1), .bus_mode_i(bus_mode),
        .bus_sdata_i(bus_sdata), .bus_ready_o(ready[1]), .bus_rvalid_o(rvalid[1]),
        .bus_rdata_o(rdata[1]), .bus_ack_o(ack[1]), .bus_err_o(err[1]),
        .bus_split_o(bsplit[1]), .split_req_o(sreq[1]), .split_grant_i(split_grant),
        .mem_valid_o(mvalid[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
        .mem_we_o(mwe[1]), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .mem_err_i(mem_err), .mem_split_start_o(msplit[1]),
        .mem_split_ready_i(mem_split_ready)
    );

    logic          c_ready, c_rvalid, c_rdata, c_ack, c_err, c_bsplit, c_sreq;
    logic          c_mvalid, c_mwe, c_msplit;
    logic [AW-1:0] c_maddr;
    logic [DW-1:0] c_mwdata;
    assign c_ready  = ready[sel];
    assign c_rvalid = rvalid[sel];
    assign c_rdata  = rdata[sel];
    assign c_ack    = ack[sel];
    assign c_err    = err[sel];
    assign c_bsplit = bsplit[sel];
    assign c_sreq   = sreq[sel];
    assign c_mvalid = mvalid[sel];
    assign c_mwe    = mwe[sel];
    assign c_msplit = msplit[sel];
    assign c_maddr  = maddr[sel];
    assign c_mwdata = mwdata[sel];

    req_t  req_q[$];
    resp_t resp_q[$];
    plan_t plan_q[$];
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit [DW-1:0] env_mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a memory request or an ack.
    initial begin
        int    rv_cnt, sreq_cnt, bs_cnt, rdy_cyc;
        logic [DW-1:0] rv_data;
        req_t  r;
        resp_t e;
        rv_cnt = 0; sreq_cnt = 0; bs_cnt = 0; rdy_cyc = -10; rv_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rv_cnt = 0; sreq_cnt = 0; bs_cnt = 0; rv_data = '0;
            end else begin
                if (c_mvalid) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_mem_valid", 32'(c_mvalid), 0);
                    end else begin
                        r = req_q.pop_front();
                        chk("mem_addr", 32'(c_maddr), 32'(r.addr));
                        chk("mem_we", 32'(c_mwe), 32'(r.we));
                        if (r.we) chk("mem_wdata", 32'(c_mwdata), 32'(r.wdata));
                        chk("mem_split_start", 32'(c_msplit), 32'(r.split));
                    end
                end
                if (mem_ready) rdy_cyc = cyc;
                if (c_sreq) begin
                    sreq_cnt++;
                    chk("bus_split_with_req", 32'(c_bsplit), 1);
                end
                if (c_bsplit) bs_cnt++;
                if (c_rvalid) begin
                    if (rv_cnt == 0 && resp_q.size() > 0 && resp_q[0].lat_chk)
                        chk("read_latency", 32'(cyc - t_last), 3);
                    rv_data = {c_rdata, rv_data[DW-1:1]};
                    rv_cnt++;
                end
                if (c_err && !c_ack) chk("err_without_ack", 32'(c_err), 0);
                if (c_ack) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(c_ack), 0);
                    end else begin
                        e = resp_q.pop_front();
                        chk("ack_err", 32'(c_err), 32'(e.err));
                        chk("rvalid_count", 32'(rv_cnt), (e.is_read && !e.err) ? DW : 0);
                        if (e.is_read && !e.err) chk("rdata", 32'(rv_data), 32'(e.data));
                        if (!e.is_read || e.err) chk("ack_after_ready", 32'(cyc - rdy_cyc), 1);
                        chk("split_req_cycles", 32'(sreq_cnt), 32'(e.sreq));
                        chk("bus_split_cycles", 32'(bs_cnt), 32'(e.bsplit));
                    end
                    rv_cnt = 0; sreq_cnt = 0; bs_cnt = 0; rv_data = '0;
                end
            end
        end
    end

    // Memory responder: acts on each request according to the plan queued with it.
    initial begin
        plan_t p;
        logic [AW-1:0] a;
        logic w;
        logic [DW-1:0] wd;
        forever begin
            @(negedge clk);
            if (rst_n && c_mvalid && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                a = c_maddr; w = c_mwe; wd = c_mwdata;
                @(posedge clk); #1;
                if (!p.split) begin
                    repeat (p.lat) begin @(posedge clk); #1; end
                    mem_ready = 1'b1; mem_err = p.err; mem_rdata = env_mem[a];
                    @(posedge clk); #1;
                    mem_ready = 1'b0; mem_err = 1'($urandom); mem_rdata = DW'($urandom);
                    if (w && !p.err) env_mem[a] = wd;
                end else begin
                    @(posedge clk); #1;
                    // Stray grant and ready while split must be ignored.
                    if (p.slat > 1) begin split_grant = 1'b1; mem_ready = 1'b1; end
                    repeat (p.slat - 1) begin
                        @(posedge clk); #1;
                        split_grant = 1'b0; mem_ready = 1'b0;
                    end
                    mem_split_ready = 1'b1; mem_rdata = env_mem[a];
                    @(posedge clk); #1;
                    mem_split_ready = 1'b0; mem_rdata = DW'($urandom);
                    repeat (p.g - 1) begin @(posedge clk); #1; end
                    split_grant = 1'b1;
                    @(posedge clk); #1;
                    split_grant = 1'b0;
                end
            end
        end
    end

    task automatic send_frame(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int abort_at, input bit sync);
        int n;
        n = we ? AW + DW : AW;
        if (sync) begin @(posedge clk); #1; end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) break;
            bus_valid = 1'b1;
            bus_mode  = (i == 0) ? we : 1'($urandom);
            if (i < AW) bus_sdata = a[i];
            else        bus_sdata = d[i - AW];
            if (i == n - 1) t_last = cyc;
            @(posedge clk); #1;
        end
        bus_valid = 1'b0;
        bus_sdata = 1'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((resp_q.size() != 0 || !c_ready) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            chk("txn_timeout", 1, 0);
            resp_q.delete(); req_q.delete(); plan_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic e_err, input int lat, input logic split, input int slat,
                       input int g, input bit sync);
        plan_t p;
        req_t  r;
        resp_t e;
        p.lat = lat; p.err = e_err; p.split = split; p.slat = slat; p.g = g;
        r.addr = a; r.we = we; r.wdata = d; r.split = sel && !we;
        e.is_read = !we; e.err = e_err; e.data = we ? '0 : ref_mem[a];
        e.sreq = split ? g : 0;
        e.bsplit = split ? slat + g : 0;
        e.lat_chk = !we && !e_err && !split && lat == 0;
        if (we && !e_err) ref_mem[a] = d;
        chk("ready_before_frame", 32'(c_ready), 1);
        plan_q.push_back(p); req_q.push_back(r); resp_q.push_back(e);
        send_frame(we, a, d, -1, sync);
        wait_done();
    endtask

    task automatic abort_frame(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int at);
        chk("ready_before_abort", 32'(c_ready), 1);
        send_frame(we, a, d, at, 1);
        @(posedge clk); #1;
        chk("ready_after_abort", 32'(c_ready), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        plan_t p;
        req_t  r;
        int    k;
        logic  we, e_err, split;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int lat, slat, g;

        rst_n = 1'b0; bus_valid = 1'b0; bus_mode = 1'b0; bus_sdata = 1'b0;
        split_grant = 1'b0; mem_ready = 1'b0; mem_err = 1'b0; mem_split_ready = 1'b0;
        mem_rdata = '0; sel = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); #1;
            chk("reset_ready", 32'(c_ready), 1);
            chk("reset_outputs", {26'd0, c_rvalid, c_ack, c_err, c_bsplit, c_sreq, c_mvalid}, 0);
            chk("reset_mem_regs", {c_maddr, c_mwdata, c_mwe, c_msplit}, 0);
        end
        sel = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Directed: write, plain read-back, error read, abort.
        txn(1, 12'h005, 8'hA5, 0, 0, 0, 1, 1, 1);
        txn(0, 12'h005, 8'h00, 0, 0, 0, 1, 1, 1);
        txn(0, 12'hFFF, 8'h00, 1, 1, 0, 1, 1, 1);
        abort_frame(0, 12'h3A7, 8'h00, 5);
        abort_frame(1, 12'h111, 8'h77, AW + 3);

        // Directed split read of a known value with a four-cycle grant holdoff.
        sel = 1'b1; @(negedge clk);
        txn(1, 12'h010, 8'h3C, 0, 1, 0, 1, 1, 1);
        txn(0, 12'h010, 8'h00, 0, 0, 1, 2, 4, 1);

        // Randomised traffic on each instance.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); @(negedge clk);
            for (int n = 0; n < 30; n++) begin
                we = 1'($urandom_range(0, 1));
                a = AW'($urandom_range(0, 7) * 37 + 16);
                d = DW'($urandom);
                if ($urandom_range(0, 9) == 0) begin
                    abort_frame(we, a, d, $urandom_range(1, we ? AW + DW - 1 : AW - 1));
                end else begin
                    e_err = ($urandom_range(0, 7) == 0);
                    lat = $urandom_range(0, 3);
                    split = sel && !we && ($urandom_range(0, 1) == 1);
                    if (split) e_err = 1'b0;
                    if (sel && !we && !split) lat = 0;
                    slat = $urandom_range(1, 4);
                    g = $urandom_range(1, 5);
                    txn(we, a, d, e_err, lat, split, slat, g, 1);
                end
            end
        end

        // Reset in the middle of a read response, then a frame right after release.
        sel = 1'b0; @(negedge clk);
        txn(1, 12'h0C3, 8'h5A, 0, 0, 0, 1, 1, 1);
        p.lat = 0; p.err = 0; p.split = 0; p.slat = 1; p.g = 1;
        r.addr = 12'h0C3; r.we = 0; r.wdata = '0; r.split = 0;
        plan_q.push_back(p); req_q.push_back(r);
        send_frame(0, 12'h0C3, 8'h00, -1, 1);
        k = 0;
        while (!c_rvalid && k < 50) begin @(negedge clk); k++; end
        chk("resp_reached", 32'(k < 50), 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midresp_reset_ready", 32'(c_ready), 1);
        chk("midresp_reset_outputs",
            {26'd0, c_rvalid, c_rdata, c_ack, c_err, c_bsplit, c_mvalid}, 0);
        chk("midresp_reset_regs", {c_maddr, c_mwdata, c_mwe}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        txn(1, 12'h2D4, 8'h96, 0, 0, 0, 1, 1, 0);
        txn(0, 12'h2D4, 8'h00, 0, 0, 0, 1, 1, 1);
        txn(0, 12'h0C3, 8'h00, 0, 2, 0, 1, 1, 1);

        repeat (4) @(negedge clk);
        chk("pending_mem_reqs", 32'(req_q.size()), 0);
        chk("pending_resps", 32'(resp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
